// File: rtl/raster_coord_gen.sv
`default_nettype none
// ============================================================================
// Module  : raster_coord_gen
// Brief   : Row-major {y,x} coordinate generator with toroidal row wrap and
//           valid/ready output handshake.
// Revision: 1.0
// ============================================================================
module raster_coord_gen #(
  parameter int CW     = 4,
  parameter int GRID_W = 8,
  parameter int GRID_H = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [CW-1:0]   start_row_i,
  input  logic [CW-1:0]   num_rows_i,
  input  logic            coord_ready_i,
  output logic            coord_valid_o,
  output logic [2*CW-1:0] coord_o,
  output logic            last_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam logic [CW-1:0] c_one    = CW'(1);
  localparam logic [CW-1:0] c_grid_w = CW'(GRID_W);
  localparam logic [CW-1:0] c_grid_h = CW'(GRID_H);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_x, w_x_nxt;
  logic [CW-1:0] r_y, w_y_nxt;
  logic [CW-1:0] r_rows_done, w_rows_done_nxt;
  logic [CW-1:0] r_num_rows, w_num_rows_nxt;
  logic [CW-1:0] w_start_row;
  logic [CW-1:0] w_num_rows;
  logic          w_last;

  // Out-of-range requests are clamped before latching.
  assign w_start_row = ((start_row_i == '0) || (start_row_i > c_grid_h)) ? c_one : start_row_i;
  assign w_num_rows  = (num_rows_i == '0)     ? c_one    :
                       (num_rows_i > c_grid_h) ? c_grid_h : num_rows_i;

  assign w_last = (r_state == S_SCAN) && (r_x == c_grid_w) &&
                  (r_rows_done == (r_num_rows - c_one));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_rows_done <= '0;
      r_num_rows  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_rows_done <= w_rows_done_nxt;
      r_num_rows  <= w_num_rows_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_x_nxt         = r_x;
    w_y_nxt         = r_y;
    w_rows_done_nxt = r_rows_done;
    w_num_rows_nxt  = r_num_rows;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_x_nxt         = c_one;
          w_y_nxt         = w_start_row;
          w_rows_done_nxt = '0;
          w_num_rows_nxt  = w_num_rows;
          w_state_nxt     = S_SCAN;
        end
      end
      S_SCAN: begin
        if (coord_ready_i) begin
          // The final coordinate stays on coord_o after the scan ends.
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else if (r_x == c_grid_w) begin
            w_x_nxt         = c_one;
            w_y_nxt         = (r_y == c_grid_h) ? c_one : (r_y + c_one);
            w_rows_done_nxt = r_rows_done + c_one;
          end else begin
            w_x_nxt = r_x + c_one;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign coord_valid_o = (r_state == S_SCAN);
  assign coord_o       = {r_y, r_x};
  assign last_o        = w_last;
  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_raster_coord_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_raster_coord_gen
// Brief   : Randomized bench for raster_coord_gen against an arithmetic model.
// Revision: 1.0
// ============================================================================
module tb_raster_coord_gen;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       rdy = 1'b0;
  logic [4:0] sr = '0;
  logic [4:0] nr = '0;

  logic       va, la, ba, da;
  logic [7:0] ca;
  logic       vb, lb, bb, db;
  logic [9:0] cb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  raster_coord_gen u_dut_a (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_a),
    .start_row_i   (sr[3:0]),
    .num_rows_i    (nr[3:0]),
    .coord_ready_i (rdy),
    .coord_valid_o (va),
    .coord_o       (ca),
    .last_o        (la),
    .busy_o        (ba),
    .done_o        (da)
  );

  raster_coord_gen #(.CW(5), .GRID_W(12), .GRID_H(10)) u_dut_b (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_b),
    .start_row_i   (sr),
    .num_rows_i    (nr),
    .coord_ready_i (rdy),
    .coord_valid_o (vb),
    .coord_o       (cb),
    .last_o        (lb),
    .busy_o        (bb),
    .done_o        (db)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] o_x(input bit sel);
    return sel ? 32'(cb[4:0]) : 32'(ca[3:0]);
  endfunction
  function automatic logic [31:0] o_y(input bit sel);
    return sel ? 32'(cb[9:5]) : 32'(ca[7:4]);
  endfunction
  function automatic logic [31:0] o_v(input bit sel);
    return sel ? 32'(vb) : 32'(va);
  endfunction
  function automatic logic [31:0] o_l(input bit sel);
    return sel ? 32'(lb) : 32'(la);
  endfunction
  function automatic logic [31:0] o_busy(input bit sel);
    return sel ? 32'(bb) : 32'(ba);
  endfunction
  function automatic logic [31:0] o_done(input bit sel);
    return sel ? 32'(db) : 32'(da);
  endfunction

  // mode: 0 ready always high, 1 random ready, 2 ready pattern 1,0,0 repeating
  task automatic run_scan(input bit sel, input int s_row, input int n_rows,
                          input int mode, input bit hold, input bit skip_start);
    int w, h, esr, enr, n, k, cyc, pat;
    bit r;
    w   = sel ? 12 : 8;
    h   = sel ? 10 : 8;
    esr = (s_row == 0 || s_row > h) ? 1 : s_row;
    enr = (n_rows == 0) ? 1 : ((n_rows > h) ? h : n_rows);
    n   = enr * w;
    if (!skip_start) begin
      @(posedge clk); #1;
      sr = 5'(s_row);
      nr = 5'(n_rows);
      if (sel) start_b = 1'b1; else start_a = 1'b1;
    end
    @(posedge clk); #1;
    if (!hold) begin
      start_a = 1'b0;
      start_b = 1'b0;
      sr = 5'($urandom_range(0, 31));
      nr = 5'($urandom_range(0, 31));
    end
    k = 0; cyc = 0; pat = 0;
    while (k < n && cyc < 2000) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (pat % 3 == 0);
      endcase
      pat++;
      rdy = r;
      @(negedge clk);
      check_val("valid", o_v(sel), 1);
      check_val("x", o_x(sel), 32'(k % w + 1));
      check_val("y", o_y(sel), 32'(((esr - 1 + k / w) % h) + 1));
      check_val("last", o_l(sel), 32'(k == n - 1));
      check_val("busy_scan", o_busy(sel), 1);
      if (r) k++;
      cyc++;
      @(posedge clk); #1;
    end
    check_val("scan_len", 32'(k), 32'(n));
    if (mode == 0) check_val("no_bubble_cycles", 32'(cyc), 32'(n));
    rdy = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_val("done_pulse", o_done(sel), 1);
    check_val("valid_in_done", o_v(sel), 0);
    check_val("busy_in_done", o_busy(sel), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("done_cleared", o_done(sel), 0);
    check_val("busy_idle", o_busy(sel), 0);
    check_val("valid_idle", o_v(sel), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check_val("rst_valid", 32'(va), 0);
    check_val("rst_coord", 32'(ca), 0);
    check_val("rst_last", 32'(la), 0);
    check_val("rst_busy", 32'(ba), 0);
    check_val("rst_done", 32'(da), 0);
    check_val("rst_coord_b", 32'(cb), 0);
    @(posedge clk); #1;
    rst_i = 1'b1;

    run_scan(0, 1, 2, 0, 0, 0);
    run_scan(0, 8, 2, 0, 0, 0);
    run_scan(0, 1, 1, 2, 0, 0);
    // start held high: second scan must follow only after done
    run_scan(0, 2, 0, 0, 1, 0);
    run_scan(0, 2, 0, 0, 0, 1);
    run_scan(0, 12, 9, 1, 0, 0);

    // reset in the middle of a scan, while {1,5} is presented
    @(posedge clk); #1;
    sr = 5'd1; nr = 5'd1; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; rdy = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check_val("pre_rst_x", 32'(ca[3:0]), 5);
    check_val("pre_rst_y", 32'(ca[7:4]), 1);
    rst_i = 1'b0;
    #1;
    check_val("async_rst_valid", 32'(va), 0);
    check_val("async_rst_coord", 32'(ca), 0);
    check_val("async_rst_last", 32'(la), 0);
    check_val("async_rst_busy", 32'(ba), 0);
    check_val("async_rst_done", 32'(da), 0);
    repeat (3) begin
      @(negedge clk);
      check_val("no_done_in_rst", 32'(da), 0);
    end
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk);
    check_val("post_rst_idle", 32'(ba), 0);
    check_val("post_rst_no_done", 32'(da), 0);
    run_scan(0, 3, 1, 1, 0, 0);

    run_scan(1, 10, 3, 0, 0, 0);

    for (int i = 0; i < 8; i++)
      run_scan(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1, 0, 0);
    for (int i = 0; i < 3; i++)
      run_scan(1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/raster_coord_gen.md
RASTER_COORD_GEN -- requirements
Module: raster_coord_gen

Interface
REQ-001 SHALL have parameter CW, 4, bit width of each coordinate field.
REQ-002 SHALL have parameter GRID_W, 8, columns per row; x runs 1..GRID_W; legal range 1..2^CW-1.
REQ-003 SHALL have parameter GRID_H, 8, rows in grid; y runs 1..GRID_H; legal range 1..2^CW-1.
REQ-004 SHALL have port clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_i  input  1  scan request pulse or level, sampled only in IDLE.
REQ-007 SHALL have port start_row_i  input  CW  first row of the scan, 1-based.
REQ-008 SHALL have port num_rows_i  input  CW  number of rows to scan.
REQ-009 SHALL have port coord_ready_i  input  1  downstream accepts the current coordinate.
REQ-010 SHALL have port coord_valid_o  output  1  coord_o holds a valid coordinate.
REQ-011 SHALL have port coord_o  output  2*CW  {y, x}; y in the upper CW bits, x in the lower CW bits.
REQ-012 SHALL have port last_o  output  1  high with coord_valid_o on the final coordinate of the scan.
REQ-013 SHALL have port busy_o  output  1  high in SCAN and DONE states.
REQ-014 SHALL have port done_o  output  1  one-cycle pulse on scan completion.

Function
REQ-015 SHALL implement states IDLE, SCAN and DONE; IDLE is the reset state.
REQ-016 In IDLE with start_i=1, SHALL latch start_row_i and num_rows_i, load x=1 and y=start_row_i, and enter SCAN.
REQ-017 SHALL assert coord_valid_o in the cycle after start is accepted, so the first coordinate appears with 1-cycle latency.
REQ-018 SHALL treat start_row_i=0 and start_row_i>GRID_H as row 1.
REQ-019 SHALL treat num_rows_i=0 as 1 and num_rows_i>GRID_H as GRID_H.
REQ-020 Handshake: a transfer SHALL occur on any cycle with coord_valid_o=1 and coord_ready_i=1.
REQ-021 While coord_valid_o=1 and coord_ready_i=0, coord_o and last_o SHALL hold their values.
REQ-022 On a transfer with x<GRID_W, x SHALL increment by 1 and y SHALL hold.
REQ-023 On a transfer with x=GRID_W, x SHALL return to 1, y SHALL advance one row, and the rows-done counter SHALL increment.
REQ-024 Row advance from y=GRID_H SHALL wrap y to 1 (toroidal scan); all coordinate arithmetic SHALL be performed in CW bits with no overflow beyond GRID_H.
REQ-025 last_o SHALL be 1 exactly when x=GRID_W and the current row is the final latched row.
REQ-026 A transfer with last_o=1 SHALL deassert coord_valid_o next cycle and move to DONE.
REQ-027 In DONE, done_o SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-028 start_i SHALL be ignored in SCAN and DONE; a new scan begins no earlier than the cycle after the return to IDLE.
REQ-029 Back-to-back transfers with coord_ready_i held at 1 SHALL produce one coordinate per cycle, with no bubbles within or between rows.
REQ-030 A full scan of R rows with ready held at 1 SHALL take R*GRID_W transfer cycles, then 1 DONE cycle.
REQ-031 coord_valid_o SHALL not depend combinationally on coord_ready_i; all outputs SHALL be registered or decoded from state.

Reset
REQ-032 While rst_i=0, SHALL asynchronously force state=IDLE, x=0, y=0, the rows counter to 0, and the latched row count to 0.
REQ-033 Output reset values SHALL be coord_valid_o=0, coord_o=0, last_o=0, busy_o=0, done_o=0.
REQ-034 Reset asserted mid-scan SHALL abort the scan with no done_o pulse; after release the block SHALL await a new start_i in IDLE.
REQ-035 Reset release SHALL be synchronised by the system; the block SHALL need no extra cycles after release before accepting start_i.

Verification
REQ-036 Defaults, start_row=1, num_rows=2, ready=1 -> coord_o sequence {1,1}..{1,8},{2,1}..{2,8}; last_o on {2,8}; done_o one cycle later; 17 cycles from first valid to done_o.
REQ-037 start_row=8, num_rows=2 -> row 8 x1..8 followed by row 1 x1..8 (wrap); last_o on {1,8}.
REQ-038 Ready toggling 1,0,0,1... on the num_rows=1 scan -> coord_o stable during stalls; exactly 8 transfers; x order 1..8 with no skips or repeats.
REQ-039 start_i held high through an entire scan -> second scan begins only after done_o, with first valid in the cycle following IDLE re-entry; num_rows=0 -> exactly 8 coordinates.
REQ-040 rst_i low at the {1,5} transfer -> outputs 0 immediately; no done_o; after release, start_row=3 scan begins cleanly at {3,1}.
REQ-041 Parameters CW=5, GRID_W=12, GRID_H=10, start_row=10, num_rows=3 -> rows 10,1,2 with x 1..12 each; 36 transfers; last_o on {2,12}.
